fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencing controller for the program counter register in the 3-stage pipeline.
- Drives the PC register's pc_in/en pair.
- Runs the request/grant handshake to instruction memory.
- Arbitrates next-PC sources (trap, mret, branch/jump, sequential) and issues flush.
- Buffers a redirect that arrives while a fetch is waiting for grant.

Parameters:
XLEN, 32, datapath/PC width
RESET_VEC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-low reset (low = reset)
pc_q  in  XLEN  current PC register output; also the imem address
pc_in  out  XLEN  next PC value to PC register
pc_en  out  1  PC register load enable
imem_req  out  1  fetch request at address pc_q
imem_gnt  in  1  memory accepts the request this cycle
stall  in  1  hazard unit: do not start a new fetch
br_taken  in  1  branch/jump resolved taken
br_target  in  XLEN  branch/jump target
mret_req  in  1  return from trap
mepc  in  XLEN  mret target
trap_req  in  1  exception/interrupt taken
trap_vec  in  XLEN  trap handler address (mtvec)
if_valid  out  1  instruction fetched last cycle is valid for decode
flush  out  1  kill younger instructions in IF/ID
misalign_err  out  1  selected redirect target had bits[1:0]!=0

Behaviour:
States: BOOT, RUN, WAIT_GNT, HOLD_REDIR.

Reset (rst=0 at posedge, any state):
- State becomes BOOT; redir_q cleared; if_valid=0.
- While in reset, outputs are pc_en=0, imem_req=0, flush=0, misalign_err=0.

BOOT (one cycle):
- pc_in=RESET_VEC, pc_en=1, imem_req=0.
- Next state: RUN.

Redirect select (combinational):
- Priority is trap_req > mret_req > br_taken.
- Target is trap_vec, mepc or br_target respectively.
- Target bits[1:0] are forced to 0. misalign_err=1 in the same cycle if they were nonzero.
- redir = any of the three requests.

RUN:
- imem_req = !stall.
- redir=1: pc_in=target, pc_en=1, flush=1. A same-cycle gnt is discarded: if_valid=0 next cycle. Stay in RUN.
- Otherwise, imem_req & gnt: pc_in=pc_q+PC_STEP (mod 2^XLEN, wraps silently), pc_en=1, if_valid=1 next cycle.
- Otherwise, imem_req & !gnt: go to WAIT_GNT, pc_en=0.
- stall=1 and no redir: pc_en=0, if_valid=0 next cycle.

WAIT_GNT:
- imem_req=1 regardless of stall. pc_q must stay stable until gnt, so pc_en=0 unless gnt.
- gnt & !redir: pc_in=pc_q+PC_STEP, pc_en=1, if_valid=1 next cycle, go to RUN.
- redir & !gnt: latch target into redir_q, flush=1, go to HOLD_REDIR.
- redir & gnt: load target directly, flush=1, discard fetch, go to RUN.

HOLD_REDIR:
- imem_req=1, pc_en=0 until gnt.
- A new redir overwrites redir_q (youngest event wins; priority still applies within a cycle) and pulses flush.
- gnt: pc_in=redir_q (or the new target if redir is also asserted), pc_en=1, if_valid=0 next cycle, go to RUN.

Global rules:
- flush is asserted exactly in cycles where redir=1 outside BOOT.
- if_valid is a 1-cycle pulse per granted, non-discarded fetch.
- Consumer: while stall=1 the IF/ID register must hold its contents, because an outstanding request completes during stall.
- Reset mid-WAIT_GNT or HOLD_REDIR drops imem_req immediately on the reset cycle. The pending redirect is lost.

Decomposition:
- Package fetch_pkg holds: fetch_state_e (BOOT, RUN, WAIT_GNT, HOLD_REDIR), redir_src_e (NONE, BR, MRET, TRAP), and constant PC_STEP.
- One natural sub-module, redirect_sel: purely combinational priority mux producing redir, target, misalign_err, src.
- FSM, redir_q and if_valid stay in fetch_ctrl.

Test Plan:
- Reset held 3 cycles, release, gnt=1 constant -> BOOT loads 0; PC sequence 0,4,8,C; if_valid pulses each cycle from the third cycle after release.
- gnt low 2 cycles at pc_q=8 -> imem_req stays 1, pc_en=0 for 2 cycles; on gnt pc_in=C, one if_valid pulse.
- WAIT_GNT at pc_q=10, br_taken to 0x100 with gnt=0, gnt 2 cycles later -> flush pulse, HOLD_REDIR, pc_in=0x100 on gnt, if_valid stays 0 for that fetch.
- trap_req (trap_vec=0x80) + br_taken (0x200) same cycle in RUN -> pc_in=0x80, flush=1, misalign_err=0; mepc=0x102 with mret -> pc_in=0x100, misalign_err=1.
- stall=1 for 3 cycles in RUN -> imem_req=0, pc_en=0, PC frozen; stall asserted in WAIT_GNT -> imem_req held 1 until gnt.
- rst=0 asserted in HOLD_REDIR with redir_q=0x40 -> next cycle BOOT, pc_in=RESET_VEC; 0x40 never loaded.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        WAIT_GNT   = 2'd2,
        HOLD_REDIR = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        MRET = 2'd2,
        TRAP = 2'd3
    } redir_src_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_ctrl_redirect_sel.sv
// Combinational priority mux over redirect sources (trap > mret > branch).
// Target is word-aligned; misalign_err flags a selected target with nonzero low bits.
module fetch_ctrl_redirect_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_mret_req,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_vec,
    output logic            o_redir,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign_err,
    output redir_src_e      o_src
);

    logic [XLEN-1:0] w_raw;

    always_comb begin
        w_raw = '0;
        o_src = NONE;
        if (i_trap_req) begin
            w_raw = i_trap_vec;
            o_src = TRAP;
        end else if (i_mret_req) begin
            w_raw = i_mepc;
            o_src = MRET;
        end else if (i_br_taken) begin
            w_raw = i_br_target;
            o_src = BR;
        end
    end

    assign o_redir        = (o_src != NONE);
    assign o_target       = {w_raw[XLEN-1:2], 2'b00};
    assign o_misalign_err = o_redir && (w_raw[1:0] != 2'b00);

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencing FSM: drives the PC register load, the imem req/gnt handshake,
// redirect arbitration and flush, and parks a redirect that lands while waiting for grant.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              PC_STEP   = fetch_pkg::PC_STEP
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc_q,
    output logic [XLEN-1:0] o_pc_in,
    output logic            o_pc_en,
    output logic            o_imem_req,
    input  logic            i_imem_gnt,
    input  logic            i_stall,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_mret_req,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_vec,
    output logic            o_if_valid,
    output logic            o_flush,
    output logic            o_misalign_err
);

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_redir_q, w_redir_q_nxt;
    logic            r_if_valid, w_if_valid_nxt;

    logic            w_redir, w_misalign, w_pc_en, w_imem_req;
    logic [XLEN-1:0] w_target, w_pc_in, w_pc_seq;
    redir_src_e      w_src;

    fetch_ctrl_redirect_sel #(.XLEN(XLEN)) u_redirect_sel (
        .i_br_taken    (i_br_taken),
        .i_br_target   (i_br_target),
        .i_mret_req    (i_mret_req),
        .i_mepc        (i_mepc),
        .i_trap_req    (i_trap_req),
        .i_trap_vec    (i_trap_vec),
        .o_redir       (w_redir),
        .o_target      (w_target),
        .o_misalign_err(w_misalign),
        .o_src         (w_src)
    );

    assign w_pc_seq = i_pc_q + XLEN'(PC_STEP);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= BOOT;
            r_redir_q  <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_redir_q  <= w_redir_q_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_redir_q_nxt  = r_redir_q;
        w_if_valid_nxt = 1'b0;
        w_pc_in        = w_pc_seq;
        w_pc_en        = 1'b0;
        w_imem_req     = 1'b0;
        case (r_state)
            BOOT: begin
                w_pc_in     = RESET_VEC;
                w_pc_en     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_imem_req = !i_stall;
                if (w_redir) begin
                    w_pc_in = w_target;
                    w_pc_en = 1'b1;
                end else if (w_imem_req && i_imem_gnt) begin
                    w_pc_en        = 1'b1;
                    w_if_valid_nxt = 1'b1;
                end else if (w_imem_req) begin
                    w_state_nxt = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                // pc_q is the live imem address, so it must not move until grant
                w_imem_req = 1'b1;
                if (w_redir && i_imem_gnt) begin
                    w_pc_in     = w_target;
                    w_pc_en     = 1'b1;
                    w_state_nxt = RUN;
                end else if (w_redir) begin
                    w_redir_q_nxt = w_target;
                    w_state_nxt   = HOLD_REDIR;
                end else if (i_imem_gnt) begin
                    w_pc_en        = 1'b1;
                    w_if_valid_nxt = 1'b1;
                    w_state_nxt    = RUN;
                end
            end
            HOLD_REDIR: begin
                w_imem_req = 1'b1;
                if (w_redir) begin
                    w_redir_q_nxt = w_target;
                end
                if (i_imem_gnt) begin
                    w_pc_in     = w_redir ? w_target : r_redir_q;
                    w_pc_en     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    assign o_pc_in        = w_pc_in;
    assign o_pc_en        = i_rst && w_pc_en;
    assign o_imem_req     = i_rst && w_imem_req;
    assign o_flush        = i_rst && (r_state != BOOT) && (w_src != NONE);
    assign o_misalign_err = i_rst && w_misalign;
    assign o_if_valid     = r_if_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl with a behavioural PC register in the loop.
module tb_fetch_ctrl;

    typedef struct {
        logic        rst, gnt, stall;
        logic        br;   logic [31:0] brt;
        logic        mret; logic [31:0] mepc;
        logic        trap; logic [31:0] tvec;
        logic [31:0] e_pcq, e_pcin;
        logic        e_en, e_req, e_fl, e_mis, e_ifv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, gnt, stall, br, mret, trap;
    logic [31:0] brt, mepc, tvec;
    logic [31:0] pc_q = 32'hDEAD_BEE0;
    logic [31:0] pc_in;
    logic        pc_en, imem_req, if_valid, flush, misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (pc_en) pc_q <= pc_in;

    fetch_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_pc_q(pc_q), .o_pc_in(pc_in), .o_pc_en(pc_en),
        .o_imem_req(imem_req), .i_imem_gnt(gnt), .i_stall(stall),
        .i_br_taken(br), .i_br_target(brt), .i_mret_req(mret), .i_mepc(mepc),
        .i_trap_req(trap), .i_trap_vec(tvec), .o_if_valid(if_valid),
        .o_flush(flush), .o_misalign_err(misalign_err)
    );

    function automatic vec_t v(logic r, logic g, logic s, logic b, logic [31:0] bt,
                               logic m, logic [31:0] me, logic t, logic [31:0] tv,
                               logic [31:0] pcq, logic [31:0] pcin, logic en,
                               logic req, logic fl, logic mis, logic ifv);
        vec_t x;
        x.rst = r; x.gnt = g; x.stall = s; x.br = b; x.brt = bt;
        x.mret = m; x.mepc = me; x.trap = t; x.tvec = tv;
        x.e_pcq = pcq; x.e_pcin = pcin; x.e_en = en; x.e_req = req;
        x.e_fl = fl; x.e_mis = mis; x.e_ifv = ifv;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        rst = x.rst; gnt = x.gnt; stall = x.stall;
        br = x.br; brt = x.brt; mret = x.mret; mepc = x.mepc; trap = x.trap; tvec = x.tvec;
        #2;
        chk("pc_q", idx, pc_q, x.e_pcq);
        chk("pc_en", idx, {31'd0, pc_en}, {31'd0, x.e_en});
        chk("imem_req", idx, {31'd0, imem_req}, {31'd0, x.e_req});
        chk("flush", idx, {31'd0, flush}, {31'd0, x.e_fl});
        chk("misalign_err", idx, {31'd0, misalign_err}, {31'd0, x.e_mis});
        chk("if_valid", idx, {31'd0, if_valid}, {31'd0, x.e_ifv});
        if (x.e_en) chk("pc_in", idx, pc_in, x.e_pcin);
    endtask

    vec_t tbl[31];

    initial begin
        rst = 1'b0; gnt = 1'b1; stall = 1'b0; br = 1'b0; mret = 1'b0; trap = 1'b0;
        brt = '0; mepc = '0; tvec = '0;

        //          rst g s  br brt     mret mepc   trap tvec      pc_q          pc_in  en req fl mis ifv
        tbl[0]  = v(0, 1, 0, 0, 0,      0, 0,       0, 0,         32'hDEADBEE0, 0,     0, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 0, 0, 0,      0, 0,       0, 0,         32'hDEADBEE0, 0,     0, 0, 0, 0, 0);
        tbl[2]  = v(0, 1, 0, 0, 0,      0, 0,       0, 0,         32'hDEADBEE0, 0,     0, 0, 0, 0, 0);
        tbl[3]  = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         32'hDEADBEE0, 0,     1, 0, 0, 0, 0);
        tbl[4]  = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h0,   'h4,   1, 1, 0, 0, 0);
        tbl[5]  = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h4,   'h8,   1, 1, 0, 0, 1);
        tbl[6]  = v(1, 0, 0, 0, 0,      0, 0,       0, 0,         'h8,   0,     0, 1, 0, 0, 1);
        tbl[7]  = v(1, 0, 0, 0, 0,      0, 0,       0, 0,         'h8,   0,     0, 1, 0, 0, 0);
        tbl[8]  = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h8,   'hC,   1, 1, 0, 0, 0);
        tbl[9]  = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'hC,   'h10,  1, 1, 0, 0, 1);
        tbl[10] = v(1, 0, 0, 0, 0,      0, 0,       0, 0,         'h10,  0,     0, 1, 0, 0, 1);
        tbl[11] = v(1, 0, 0, 1, 'h100,  0, 0,       0, 0,         'h10,  0,     0, 1, 1, 0, 0);
        tbl[12] = v(1, 0, 0, 0, 0,      0, 0,       0, 0,         'h10,  0,     0, 1, 0, 0, 0);
        tbl[13] = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h10,  'h100, 1, 1, 0, 0, 0);
        tbl[14] = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h100, 'h104, 1, 1, 0, 0, 0);
        tbl[15] = v(1, 1, 0, 1, 'h200,  0, 0,       1, 'h80,      'h104, 'h80,  1, 1, 1, 0, 1);
        tbl[16] = v(1, 1, 0, 0, 0,      1, 'h102,   0, 0,         'h80,  'h100, 1, 1, 1, 1, 0);
        tbl[17] = v(1, 1, 1, 0, 0,      0, 0,       0, 0,         'h100, 0,     0, 0, 0, 0, 0);
        tbl[18] = v(1, 1, 1, 0, 0,      0, 0,       0, 0,         'h100, 0,     0, 0, 0, 0, 0);
        tbl[19] = v(1, 1, 1, 0, 0,      0, 0,       0, 0,         'h100, 0,     0, 0, 0, 0, 0);
        tbl[20] = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h100, 'h104, 1, 1, 0, 0, 0);
        tbl[21] = v(1, 0, 0, 0, 0,      0, 0,       0, 0,         'h104, 0,     0, 1, 0, 0, 1);
        tbl[22] = v(1, 0, 1, 0, 0,      0, 0,       0, 0,         'h104, 0,     0, 1, 0, 0, 0);
        tbl[23] = v(1, 1, 1, 0, 0,      0, 0,       0, 0,         'h104, 'h108, 1, 1, 0, 0, 0);
        tbl[24] = v(1, 1, 1, 0, 0,      0, 0,       0, 0,         'h108, 0,     0, 0, 0, 0, 1);
        tbl[25] = v(1, 0, 0, 0, 0,      0, 0,       0, 0,         'h108, 0,     0, 1, 0, 0, 0);
        tbl[26] = v(1, 0, 0, 1, 'h20,   0, 0,       0, 0,         'h108, 0,     0, 1, 1, 0, 0);
        tbl[27] = v(1, 0, 0, 0, 0,      0, 0,       1, 'h41,      'h108, 0,     0, 1, 1, 1, 0);
        tbl[28] = v(0, 1, 0, 0, 0,      0, 0,       0, 0,         'h108, 0,     0, 0, 0, 0, 0);
        tbl[29] = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h108, 'h0,   1, 0, 0, 0, 0);
        tbl[30] = v(1, 1, 0, 0, 0,      0, 0,       0, 0,         'h0,   'h4,   1, 1, 0, 0, 0);

        for (int i = 0; i < 31; i++) apply(tbl[i], i);

        // HOLD_REDIR overwritten by a redirect arriving together with the grant
        apply(v(1, 0, 0, 0, 0,     0, 0, 0, 0, 'h4,   0,     0, 1, 0, 0, 1), 100);
        apply(v(1, 0, 0, 1, 'h200, 0, 0, 0, 0, 'h4,   0,     0, 1, 1, 0, 0), 101);
        apply(v(1, 1, 0, 1, 'h300, 0, 0, 0, 0, 'h4,   'h300, 1, 1, 1, 0, 0), 102);
        // sequential increment wraps at the top of the address space
        apply(v(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 'h300, 32'hFFFF_FFFC, 1, 1, 1, 0, 0), 103);
        apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 'h0, 1, 1, 0, 0, 0), 104);
        apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 'h0,   'h4,   1, 1, 0, 0, 1), 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
